// File: rtl/counter_sched_if.sv
// Client-side bundle for the shared delay-counter scheduler.
// Clients drive req/delay; the scheduler answers with gnt/done and exposes busy/out.
interface counter_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] delay;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [W-1:0]      out;

   modport master (output req, delay, input gnt, done, busy, out);
   modport slave  (input req, delay, output gnt, done, busy, out);
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler time-sharing one W-bit up-counter among NREQ requesters.
//
// state | meaning
// IDLE  | no owner; arbitrate from ptr on each edge while any req is set
// RUN   | counter owned by idx, counting 0..dly
// DONE  | one-cycle done pulse to idx, then hand ptr to the next requester
module counter_sched #(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   counter_sched_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx, idx_nxt, ptr, ptr_nxt, win, idx_inc;
   logic            found;
   logic [W-1:0]    dly, dly_nxt, cnt, cnt_nxt;
   logic [NREQ-1:0] gnt, gnt_nxt, done, done_nxt;

   // first set request at or after ptr, wrapping
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && bus.req[(int'(ptr) + k) % NREQ]) begin
            win   = IW'((int'(ptr) + k) % NREQ);
            found = 1'b1;
         end
      end
   end

   assign idx_inc = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         dly   <= '0;
         ptr   <= '0;
         cnt   <= '0;
         gnt   <= '0;
         done  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         dly   <= dly_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      dly_nxt   = dly;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      done_nxt  = '0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            gnt_nxt = '0;
            if (found) begin
               idx_nxt   = win;
               dly_nxt   = bus.delay[int'(win)*W +: W];
               gnt_nxt   = NREQ'(1) << win;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // a dropped request aborts even on the terminal count
            if (!bus.req[idx]) begin
               gnt_nxt   = '0;
               cnt_nxt   = '0;
               ptr_nxt   = idx_inc;
               state_nxt = IDLE;
            end else if (cnt == dly) begin
               gnt_nxt   = '0;
               done_nxt  = NREQ'(1) << idx;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            cnt_nxt   = '0;
            ptr_nxt   = idx_inc;
            state_nxt = IDLE;
         end
         default: begin
            gnt_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.gnt  = gnt;
      bus.done = done;
      bus.out  = cnt;
      bus.busy = (state != IDLE);
   end
endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: grant/count/done timing, round-robin order,
// full-range count, abort and asynchronous reset.
module tb_counter_sched;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   counter_sched_if #(.NREQ(NREQ), .W(W)) bus ();

   counter_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_delay(input int i, input logic [W-1:0] v);
      bus.delay[i*W +: W] = v;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_gnt"},  32'(bus.gnt),  32'h0);
      check_val({tag, "_done"}, 32'(bus.done), 32'h0);
      check_val({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check_val({tag, "_out"},  32'(bus.out),  32'h0);
   endtask

   // grant/done exclusivity on every cycle
   always @(negedge clk) begin
      check_val("gnt_onehot0",  32'($onehot0(bus.gnt)),  32'h1);
      check_val("done_onehot0", 32'($onehot0(bus.done)), 32'h1);
      check_val("gnt_done_excl", 32'((|bus.gnt) && (|bus.done)), 32'h0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req   = '0;
      bus.delay = '0;
      step();
      step();
      check_idle("rst_hold");
      #2 rst = 1'b0;
      step();
      check_idle("rst_release");

      // single request, delay 3
      set_delay(0, 8'd3);
      bus.req = 4'b0001;
      step();
      for (int k = 0; k < 4; k++) begin
         check_val("t2_gnt",  32'(bus.gnt),  32'h1);
         check_val("t2_out",  32'(bus.out),  32'(k));
         check_val("t2_done", 32'(bus.done), 32'h0);
         check_val("t2_busy", 32'(bus.busy), 32'h1);
         step();
      end
      check_val("t2_done_pulse", 32'(bus.done), 32'h1);
      check_val("t2_done_gnt",   32'(bus.gnt),  32'h0);
      check_val("t2_done_out",   32'(bus.out),  32'h3);
      check_val("t2_done_busy",  32'(bus.busy), 32'h1);
      bus.req = 4'b0000;
      step();
      check_idle("t2_after");

      // reset to bring ptr back to 0, then all four with zero delay
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.delay = '0;
      bus.req   = 4'b1111;
      for (int g = 0; g < 6; g++) begin
         step();
         check_val("t3_gnt",      32'(bus.gnt),  32'(1 << (g % 4)));
         check_val("t3_gnt_out",  32'(bus.out),  32'h0);
         check_val("t3_gnt_done", 32'(bus.done), 32'h0);
         step();
         check_val("t3_done",     32'(bus.done), 32'(1 << (g % 4)));
         check_val("t3_done_gnt", 32'(bus.gnt),  32'h0);
         step();
         check_val("t3_gap_gnt",  32'(bus.gnt),  32'h0);
         check_val("t3_gap_busy", 32'(bus.busy), 32'h0);
      end
      bus.req = 4'b0000;
      step();
      check_idle("t3_after");

      // full-range count; ptr is 2 so requester 0 wins after wrap
      set_delay(0, 8'hFF);
      bus.req = 4'b0001;
      step();
      for (int k = 0; k < 256; k++) begin
         check_val("t4_out", 32'(bus.out), 32'(k));
         check_val("t4_gnt", 32'(bus.gnt), 32'h1);
         if (k == 10) set_delay(0, 8'd5);
         step();
      end
      check_val("t4_done",     32'(bus.done), 32'h1);
      check_val("t4_done_out", 32'(bus.out),  32'hFF);
      check_val("t4_done_gnt", 32'(bus.gnt),  32'h0);
      bus.req = 4'b0000;
      step();
      check_idle("t4_after");

      // abort requester 1 at out==2
      set_delay(1, 8'd10);
      bus.req = 4'b0010;
      step();
      check_val("t5_gnt", 32'(bus.gnt), 32'h2);
      step();
      step();
      check_val("t5_out2", 32'(bus.out), 32'h2);
      bus.req = 4'b0001;
      step();
      check_idle("t5_abort");
      bus.req = 4'b0011;
      step();
      check_val("t5_next_gnt", 32'(bus.gnt), 32'h1);
      check_val("t5_next_out", 32'(bus.out), 32'h0);
      bus.req = 4'b0000;
      step();
      check_idle("t5_after");

      // reset while requester 3 is at out==5
      set_delay(3, 8'd10);
      bus.req = 4'b1000;
      step();
      check_val("t6_gnt", 32'(bus.gnt), 32'h8);
      for (int k = 0; k < 5; k++) step();
      check_val("t6_out5", 32'(bus.out), 32'h5);
      #3 rst = 1'b1;
      #1;
      check_idle("t6_async");
      bus.req = 4'b1001;
      step();
      check_idle("t6_hold");
      rst = 1'b0;
      step();
      check_val("t6_fresh_gnt",  32'(bus.gnt),  32'h1);
      check_val("t6_fresh_out",  32'(bus.out),  32'h0);
      check_val("t6_fresh_done", 32'(bus.done), 32'h0);
      step();
      check_val("t6_count", 32'(bus.out), 32'h1);
      bus.req = 4'b0000;
      step();
      check_idle("t6_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Round-robin scheduler that time-shares one W-bit up-counter (delay timer) among NREQ requesters. Each requester asks for a delay of D cycles. The block grants the counter to one requester at a time, runs it from 0 to D, and then pulses that requester's done line. It sits between the client blocks and the shared counter datapath. It exposes the running count on out so the count stays observable exactly as the standalone counter's is.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, counter/delay width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; must be held until done
delay  input  NREQ*W  per-requester delay; slice i = delay[i*W +: W], sampled at grant
gnt  output  NREQ  one-hot grant, held while that requester owns the counter
done  output  NREQ  one-cycle completion pulse to the granted requester
busy  output  1  high whenever state != IDLE
out  output  W  current counter value

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, done=0, out=0, busy=0, rr pointer ptr=0, latched index/delay=0. Takes effect immediately, not at the next edge. Any in-flight run is discarded and no done is issued.
- FSM states are IDLE, RUN and DONE. Internal registers: idx (granted requester), dly (latched W-bit delay), ptr (round-robin start).
- IDLE:
  - If req==0: hold state, out=0.
  - Else: pick the first set req bit searching ptr, ptr+1, …, wrapping mod NREQ.
  - On that edge: idx<=winner, dly<=delay slice of winner, gnt<=onehot(winner), out<=0, state<=RUN.
- RUN: evaluated each edge.
  - Abort: if req[idx]==0, then gnt<=0, out<=0, ptr<=(idx+1) mod NREQ, state<=IDLE. No done pulse. Abort has priority over completion.
  - Completion: else if out==dly, then gnt<=0, done<=onehot(idx), state<=DONE. out holds dly.
  - Otherwise: out<=out+1.
- DONE: one cycle only. On the edge: done<=0, out<=0, ptr<=(idx+1) mod NREQ, state<=IDLE.
- Timing from the IDLE edge that grants:
  - gnt is high for exactly dly+1 cycles.
  - out shows 0,1,…,dly, one value per cycle.
  - done is high for the single cycle immediately after gnt falls.
  - The next grant is visible no earlier than 2 cycles after done rises (DONE→IDLE→RUN).
- dly=0: gnt high for 1 cycle with out=0, then done.
- dly=2^W-1: out counts up to 2^W-1 and never wraps; the counter cannot wrap by construction.
- delay inputs are ignored except on the granting edge. Changing them during RUN has no effect.
- req of non-granted requesters may toggle freely; they affect only the next arbitration.
- A requester still asserting req after its done is treated as a new request. Round-robin order guarantees it waits behind the other pending requesters.
- At most one bit of gnt and at most one bit of done is high at any time. gnt and done are never high in the same cycle.

Test Plan:
1. Assert and release rst mid-stream → gnt=0, done=0, busy=0, out=0 while rst=1 and on release; the first grant after reset goes to the lowest pending index.
2. req=4'b0001, delay[0]=3 → gnt=4'b0001 for 4 cycles, out=0,1,2,3, then done=4'b0001 for 1 cycle; busy high for 5 cycles.
3. req=4'b1111, all delays 0, held continuously → grant order 0,1,2,3,0,1; each gnt lasts 1 cycle and consecutive grants are 3 cycles apart; exactly one done per grant.
4. req=4'b0001, delay[0]=8'hFF → gnt held 256 cycles, out reaches 8'hFF with no wrap to 0, then a single done pulse.
5. req=4'b0010, delay[1]=10, drop req[1] when out==2 → gnt falls on the next edge, out returns to 0, no done. With req=4'b0011 pending, the next grant goes to requester 0 after ptr wraps (2,3,0).
6. rst pulsed while RUN with out==5 → outputs clear asynchronously and no done fires. After release with req still set, a fresh run starts with out=0 and ptr=0.
